// File: rtl/snake_pkg.sv
// ==========================================================================
// snake_pkg: direction, state and collision codes shared by the snake engine
// Rev 1.0
// ==========================================================================
`default_nettype none

package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    COLL_NONE = 2'b00,
    COLL_WALL = 2'b01,
    COLL_SELF = 2'b10
  } coll_t;

  // Opposite directions differ only in bit 0 of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_seg_match.sv
// ==========================================================================
// snake_seg_match: compares one grid cell against the first `count` segments
// Rev 1.0
// ==========================================================================
`default_nettype none

module snake_seg_match
  import snake_pkg::*;
#(
  parameter int COL_W   = 7,
  parameter int ROW_W   = 6,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] seg_col [MAX_LEN],
  input  logic [ROW_W-1:0] seg_row [MAX_LEN],
  input  logic [LEN_W-1:0] count,
  output logic             hit
);

  logic [MAX_LEN-1:0] match;

  generate
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
      localparam logic [LEN_W-1:0] IDX = LEN_W'(i);
      assign match[i] = (IDX < count) && (seg_col[i] == col) && (seg_row[i] == row);
    end
  endgenerate

  assign hit = |match;

endmodule

`default_nettype wire

// File: rtl/snake_body_engine.sv
// ==========================================================================
// snake_body_engine: grid snake with shift-register body, collisions and pixel hit
// Rev 1.0
// ==========================================================================
`default_nettype none

module snake_body_engine
  import snake_pkg::*;
#(
  parameter  int BIT       = 10,
  parameter  int CELL_LOG2 = 3,
  parameter  int COLS      = 80,
  parameter  int ROWS      = 60,
  parameter  int MAX_LEN   = 16,
  parameter  int INIT_LEN  = 3,
  parameter  int START_COL = 40,
  parameter  int START_ROW = 30,
  parameter  int WRAP      = 0,
  localparam int COL_W     = $clog2(COLS),
  localparam int ROW_W     = $clog2(ROWS),
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             grow,
  input  logic [1:0]       dir,
  input  logic [BIT-1:0]   x_pos,
  input  logic [BIT-1:0]   y_pos,
  output logic             head_active,
  output logic             body_active,
  output logic             alive,
  output logic [1:0]       collision,
  output logic [LEN_W-1:0] length,
  output logic [COL_W-1:0] head_col,
  output logic [ROW_W-1:0] head_row
);

  localparam logic [BIT:0] X_LIMIT = (BIT+1)'(COLS << CELL_LOG2);
  localparam logic [BIT:0] Y_LIMIT = (BIT+1)'(ROWS << CELL_LOG2);

  state_t           state;
  dir_t             cur_dir;
  logic             grow_pend;
  logic [COL_W-1:0] seg_col [MAX_LEN];
  logic [ROW_W-1:0] seg_row [MAX_LEN];

  dir_t             dir_in;
  dir_t             next_dir;
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic             wall_hit;
  logic             self_hit;
  logic             grow_now;
  logic [LEN_W-1:0] tail_count;
  logic             do_init;

  assign dir_in   = dir_t'(dir);
  assign next_dir = (dir_in == reverse_dir(cur_dir)) ? cur_dir : dir_in;
  assign grow_now = grow_pend | grow;
  // The tail cell is vacated by this step unless the snake lengthens.
  assign tail_count = grow_now ? length : length - 1'b1;
  assign do_init    = reset | (start & (state != ST_RUN));

  always_comb begin
    nxt_col  = head_col;
    nxt_row  = head_row;
    wall_hit = 1'b0;
    case (next_dir)
      DIR_UP: begin
        if (head_row == '0) begin
          if (WRAP != 0) nxt_row = ROW_W'(ROWS - 1);
          else           wall_hit = 1'b1;
        end else nxt_row = head_row - 1'b1;
      end
      DIR_DOWN: begin
        if (head_row == ROW_W'(ROWS - 1)) begin
          if (WRAP != 0) nxt_row = '0;
          else           wall_hit = 1'b1;
        end else nxt_row = head_row + 1'b1;
      end
      DIR_LEFT: begin
        if (head_col == '0) begin
          if (WRAP != 0) nxt_col = COL_W'(COLS - 1);
          else           wall_hit = 1'b1;
        end else nxt_col = head_col - 1'b1;
      end
      default: begin
        if (head_col == COL_W'(COLS - 1)) begin
          if (WRAP != 0) nxt_col = '0;
          else           wall_hit = 1'b1;
        end else nxt_col = head_col + 1'b1;
      end
    endcase
  end

  snake_seg_match #(
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_head_match (
    .col    (nxt_col),
    .row    (nxt_row),
    .seg_col(seg_col),
    .seg_row(seg_row),
    .count  (tail_count),
    .hit    (self_hit)
  );

  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic             pix_in;
  logic             pix_body;
  logic             unused_pix_bits;

  assign pix_col = x_pos[CELL_LOG2 +: COL_W];
  assign pix_row = y_pos[CELL_LOG2 +: ROW_W];
  assign pix_in  = ({1'b0, x_pos} < X_LIMIT) && ({1'b0, y_pos} < Y_LIMIT);
  assign unused_pix_bits = ^{x_pos[CELL_LOG2-1:0], y_pos[CELL_LOG2-1:0]};

  snake_seg_match #(
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_pix_match (
    .col    (pix_col),
    .row    (pix_row),
    .seg_col(seg_col),
    .seg_row(seg_row),
    .count  (length),
    .hit    (pix_body)
  );

  always_ff @(posedge clk) begin
    head_active <= ~reset & pix_in & (pix_col == head_col) & (pix_row == head_row);
    body_active <= ~reset & pix_in & pix_body;
    if (do_init) begin
      state     <= reset ? ST_IDLE : ST_RUN;
      alive     <= ~reset;
      head_col  <= COL_W'(START_COL);
      head_row  <= ROW_W'(START_ROW);
      length    <= LEN_W'(INIT_LEN);
      cur_dir   <= DIR_RIGHT;
      grow_pend <= 1'b0;
      collision <= COLL_NONE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_col[i] <= COL_W'(START_COL - 1 - i);
        seg_row[i] <= ROW_W'(START_ROW);
      end
    end else if (state == ST_RUN) begin
      if (step) begin
        cur_dir <= next_dir;
        if (wall_hit) begin
          state     <= ST_DEAD;
          alive     <= 1'b0;
          collision <= COLL_WALL;
        end else if (self_hit) begin
          state     <= ST_DEAD;
          alive     <= 1'b0;
          collision <= COLL_SELF;
        end else begin
          seg_col[0] <= head_col;
          seg_row[0] <= head_row;
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_col[i] <= seg_col[i-1];
            seg_row[i] <= seg_row[i-1];
          end
          head_col <= nxt_col;
          head_row <= nxt_row;
          if (grow_now) begin
            if (length != LEN_W'(MAX_LEN)) length <= length + 1'b1;
            grow_pend <= 1'b0;
          end
        end
      end else if (grow) begin
        grow_pend <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snake_body_engine.sv
// ==========================================================================
// tb_snake_body_engine: directed stimulus on a wall and a wrap instance vs. a grid model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_snake_body_engine;

  localparam int MAX_LEN = 16;
  localparam int COLS    = 80;
  localparam int ROWS    = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       grow = 1'b0;
  logic [1:0] dir = 2'b11;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;

  logic       ha0, ba0, al0, ha1, ba1, al1;
  logic [1:0] co0, co1;
  logic [4:0] le0, le1;
  logic [6:0] hc0, hc1;
  logic [5:0] hr0, hr1;

  always #5 clk = ~clk;

  snake_body_engine #(.WRAP(0)) u_wall (
    .clk(clk), .reset(reset), .start(start), .step(step), .grow(grow), .dir(dir),
    .x_pos(x_pos), .y_pos(y_pos), .head_active(ha0), .body_active(ba0), .alive(al0),
    .collision(co0), .length(le0), .head_col(hc0), .head_row(hr0)
  );

  snake_body_engine #(.WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .step(step), .grow(grow), .dir(dir),
    .x_pos(x_pos), .y_pos(y_pos), .head_active(ha1), .body_active(ba1), .alive(al1),
    .collision(co1), .length(le1), .head_col(hc1), .head_row(hr1)
  );

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: snake as a list of grid cells; state 0 idle, 1 run, 2 dead. Index 1 wraps.
  int m_state[2], m_hc[2], m_hr[2], m_len[2], m_dir[2], m_pend[2], m_coll[2];
  int m_ha[2], m_ba[2];
  int m_sc[2][MAX_LEN];
  int m_sr[2][MAX_LEN];

  function automatic bit on_body(input int k, input int c, input int r, input int n);
    for (int i = 0; i < n; i++)
      if (m_sc[k][i] == c && m_sr[k][i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_init(input int k);
    m_hc[k] = 40; m_hr[k] = 30; m_len[k] = 3; m_dir[k] = 3; m_pend[k] = 0; m_coll[k] = 0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m_sc[k][i] = 39 - i;
      m_sr[k][i] = 30;
    end
  endtask

  task automatic m_update(input int k);
    int cx, cy, d, nc, nr;
    bit inr, wall, grows;
    cx  = int'(x_pos) / 8;
    cy  = int'(y_pos) / 8;
    inr = (x_pos < 640) && (y_pos < 480);
    if (reset) begin
      m_init(k);
      m_state[k] = 0; m_ha[k] = 0; m_ba[k] = 0;
      return;
    end
    m_ha[k] = int'(inr && cx == m_hc[k] && cy == m_hr[k]);
    m_ba[k] = int'(inr && on_body(k, cx, cy, m_len[k]));
    if (m_state[k] != 1) begin
      if (start) begin
        m_init(k);
        m_state[k] = 1;
      end
    end else if (step) begin
      d = int'(dir);
      if ((d == 0 && m_dir[k] == 1) || (d == 1 && m_dir[k] == 0) ||
          (d == 2 && m_dir[k] == 3) || (d == 3 && m_dir[k] == 2)) d = m_dir[k];
      m_dir[k] = d;
      nc = m_hc[k]; nr = m_hr[k];
      case (d)
        0: nr = nr - 1;
        1: nr = nr + 1;
        2: nc = nc - 1;
        default: nc = nc + 1;
      endcase
      wall = 1'b0;
      if (k == 1) begin
        nc = (nc + COLS) % COLS;
        nr = (nr + ROWS) % ROWS;
      end else begin
        wall = (nc < 0) || (nc >= COLS) || (nr < 0) || (nr >= ROWS);
      end
      grows = (m_pend[k] != 0) || grow;
      if (wall) begin
        m_state[k] = 2; m_coll[k] = 1;
      end else if (on_body(k, nc, nr, grows ? m_len[k] : m_len[k] - 1)) begin
        m_state[k] = 2; m_coll[k] = 2;
      end else begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          m_sc[k][i] = m_sc[k][i-1];
          m_sr[k][i] = m_sr[k][i-1];
        end
        m_sc[k][0] = m_hc[k]; m_sr[k][0] = m_hr[k];
        m_hc[k] = nc; m_hr[k] = nr;
        if (grows) begin
          if (m_len[k] < MAX_LEN) m_len[k]++;
          m_pend[k] = 0;
        end
      end
    end else if (grow) begin
      m_pend[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    m_update(0);
    m_update(1);
  end

  task automatic cmp_inst(input int k, input logic al, input logic [1:0] co, input logic [4:0] le,
                          input logic [6:0] hc, input logic [5:0] hr, input logic ha, input logic ba);
    check($sformatf("alive%0d", k),     int'(al), int'(m_state[k] == 1));
    check($sformatf("collision%0d", k), int'(co), m_coll[k]);
    check($sformatf("length%0d", k),    int'(le), m_len[k]);
    check($sformatf("head_col%0d", k),  int'(hc), m_hc[k]);
    check($sformatf("head_row%0d", k),  int'(hr), m_hr[k]);
    check($sformatf("head_active%0d", k), int'(ha), m_ha[k]);
    check($sformatf("body_active%0d", k), int'(ba), m_ba[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, al0, co0, le0, hc0, hr0, ha0, ba0);
      cmp_inst(1, al1, co1, le1, hc1, hr1, ha1, ba1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d, input logic g);
    step = 1'b1; dir = d; grow = g;
    tick();
    step = 1'b0; grow = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    x_pos = 10'(x); y_pos = 10'(y);
    tick();
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state and pixel hits of the frozen snake in IDLE.
    check("reset_alive", int'(al0), 0);
    check("reset_length", int'(le0), 3);
    check("reset_head_col", int'(hc0), 40);
    pix(323, 245); check("pix_head", int'(ha0), 1);
    pix(319, 245); check("pix_body", int'(ba0), 1);
    pix(296, 245); check("pix_tail", int'(ba0), 1);
    pix(288, 245); check("pix_past_tail", int'(ba0), 0);
    pix(640, 245); check("pix_off_h", int'(ha0) + int'(ba0), 0);
    pix(0, 0);

    // Three steps right from start.
    do_start();
    repeat (3) do_step(2'b11, 1'b0);
    check("t1_head_col", int'(hc0), 43);
    check("t1_head_row", int'(hr0), 30);
    check("t1_length", int'(le0), 3);
    check("t1_alive", int'(al0), 1);
    check("t1_coll", int'(co0), 0);
    pix(336, 240); check("t1_seg0", int'(ba0), 1);
    do_start();
    check("t1_start_ignored", int'(hc0), 43);

    // Reversal ignored.
    do_reset(); do_start();
    do_step(2'b10, 1'b0);
    check("t2_reverse", int'(hc0), 41);

    // Right wall vs wrap.
    do_reset(); do_start();
    repeat (39) do_step(2'b11, 1'b0);
    check("t3_at_edge", int'(hc0), 79);
    do_step(2'b11, 1'b0);
    check("t3_wall_coll", int'(co0), 1);
    check("t3_wall_alive", int'(al0), 0);
    check("t3_wall_col", int'(hc0), 79);
    check("t3_wrap_col", int'(hc1), 0);
    check("t3_wrap_alive", int'(al1), 1);
    do_step(2'b00, 1'b0);
    check("t3_dead_frozen", int'(hr0), 30);
    do_start();
    check("t3_restart", int'(hc0), 40);

    // Growth saturates at MAX_LEN.
    do_reset(); do_start();
    for (int i = 0; i < 20; i++) do_step(2'b11, 1'b1);
    check("t4_length", int'(le0), 16);
    check("t4_coll", int'(co0), 0);
    check("t4_head_col", int'(hc0), 60);
    do_step(2'b11, 1'b0);
    check("t4_hold", int'(le0), 16);

    // Self collision when grown, legal path when tail vacates.
    do_reset(); do_start();
    do_step(2'b11, 1'b1);
    do_step(2'b00, 1'b0);
    do_step(2'b10, 1'b0);
    do_step(2'b01, 1'b0);
    check("t5_self_coll", int'(co0), 2);
    check("t5_self_alive", int'(al0), 0);
    check("t5_self_row", int'(hr0), 29);
    do_reset(); do_start();
    do_step(2'b11, 1'b0);
    do_step(2'b00, 1'b0);
    do_step(2'b10, 1'b0);
    do_step(2'b01, 1'b0);
    check("t5_legal_coll", int'(co0), 0);
    check("t5_legal_alive", int'(al0), 1);
    check("t5_legal_pos", int'(hc0) * 100 + int'(hr0), 4030);

    // Reset in RUN beats a simultaneous step.
    reset = 1'b1; step = 1'b1;
    tick();
    reset = 1'b0; step = 1'b0;
    check("t7_reset_alive", int'(al0), 0);
    check("t7_reset_col", int'(hc0), 40);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
